c4_win_scanner: RTL and testbench

C4_WIN_SCANNER -- requirements
Module: c4_win_scanner

---
 rtl/c4_pkg.sv | 43 ++++
 rtl/c4_window_check.sv | 20 ++
 rtl/c4_win_scanner.sv | 158 +++++++++++++++
 tb/tb_c4_win_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared constants and types for the connect-four win scanner.
// Board is 6 rows by 7 columns, address = row*7 + col, row 0 at the bottom.
package c4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  localparam int LOAD_CYCLES  = CELLS + 1;
  localparam int CHECK_CYCLES = CELLS;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int NDIR = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } scan_state_e;

  // 2'b11 is not a player, so it counts as a free cell
  function automatic logic is_empty(input logic [1:0] c);
    return (c != CELL_P1) && (c != CELL_P2);
  endfunction

  // Address stride of each direction: horizontal, vertical, up-right, up-left
  function automatic int dir_step(input int d);
    int s;
    s = 1;
    unique case (d)
      0:       s = 1;
      1:       s = COLS;
      2:       s = COLS + 1;
      default: s = COLS - 1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/c4_window_check.sv
// Four-cell window comparator for the win scanner.
// Purely combinational: flags a window held entirely by one player.
module c4_window_check
  import c4_pkg::*;
(
  input  logic [1:0] cell0,
  input  logic [1:0] cell1,
  input  logic [1:0] cell2,
  input  logic [1:0] cell3,
  output logic       p1_match,
  output logic       p2_match
);

  assign p1_match = (cell0 == CELL_P1) && (cell1 == CELL_P1) &&
                    (cell2 == CELL_P1) && (cell3 == CELL_P1);

  assign p2_match = (cell0 == CELL_P2) && (cell1 == CELL_P2) &&
                    (cell2 == CELL_P2) && (cell3 == CELL_P2);

endmodule

// File: rtl/c4_win_scanner.sv
// Connect-four board scanner: copies the board RAM into a shadow,
// then sweeps every anchor testing four directions for a win or tie.
module c4_win_scanner
  import c4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] read_pos,
  input  logic [1:0] read_data,
  output logic       busy,
  output logic       done,
  output logic       p1_four_row,
  output logic       p2_four_row,
  output logic       tie_game
);

  scan_state_e state_q, state_d;

  logic [5:0] addr_q, addr_d;
  logic [5:0] anchor_q, anchor_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  logic [2*CELLS-1:0] board_q;
  logic [5:0]         cap;

  logic hit_p1_q, hit_p2_q, empty_q;
  logic done_q, p1_q, p2_q, tie_q;
  logic accept;

  logic [1:0] win [NDIR][4];
  logic [3:0] dir_ok;
  logic [3:0] p1_m, p2_m;

  // The done cycle lands in IDLE, so a start there must still be refused
  assign accept = (state_q == S_IDLE) && start && !done_q;
  assign cap    = addr_q - 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  if (addr_q == 6'(LOAD_CYCLES - 1)) state_d = S_CHECK;
      S_CHECK: if (anchor_q == 6'(CHECK_CYCLES - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE) || done_q;
    read_pos = '0;
    if (state_q == S_LOAD && addr_q < 6'(CELLS)) read_pos = addr_q;
  end

  always_comb begin
    addr_d   = '0;
    anchor_d = '0;
    row_d    = '0;
    col_d    = '0;
    if (state_q == S_LOAD && state_d == S_LOAD) addr_d = addr_q + 6'd1;
    if (state_q == S_CHECK && state_d == S_CHECK) begin
      anchor_d = anchor_q + 6'd1;
      row_d    = row_q;
      col_d    = col_q + 3'd1;
      if (col_q == 3'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int d = 0; d < NDIR; d++) begin
      for (int k = 0; k < 4; k++) begin
        win[d][k] = CELL_EMPTY;
        idx = int'(anchor_q) + k * dir_step(d);
        if (idx < CELLS) win[d][k] = board_q[2*idx +: 2];
      end
    end
  end

  // Windows that would run off the board are masked out here
  assign dir_ok[0] = (col_q <= 3'd3);
  assign dir_ok[1] = (row_q <= 3'd2);
  assign dir_ok[2] = (col_q <= 3'd3) && (row_q <= 3'd2);
  assign dir_ok[3] = (col_q >= 3'd3) && (row_q <= 3'd2);

  for (genvar d = 0; d < NDIR; d++) begin : g_dir
    c4_window_check u_chk (
      .cell0    (win[d][0]),
      .cell1    (win[d][1]),
      .cell2    (win[d][2]),
      .cell3    (win[d][3]),
      .p1_match (p1_m[d]),
      .p2_match (p2_m[d])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      anchor_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      board_q  <= '0;
      hit_p1_q <= 1'b0;
      hit_p2_q <= 1'b0;
      empty_q  <= 1'b0;
      done_q   <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      anchor_q <= anchor_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= (state_q == S_DONE);
      if (accept) begin
        hit_p1_q <= 1'b0;
        hit_p2_q <= 1'b0;
        empty_q  <= 1'b0;
      end
      // RAM data trails the address by one cycle
      if (state_q == S_LOAD && addr_q != 6'd0) begin
        board_q[{cap, 1'b0} +: 2] <= read_data;
        if (is_empty(read_data)) empty_q <= 1'b1;
      end
      if (state_q == S_CHECK) begin
        hit_p1_q <= hit_p1_q | (|(dir_ok & p1_m));
        hit_p2_q <= hit_p2_q | (|(dir_ok & p2_m));
      end
      if (state_q == S_DONE) begin
        p1_q  <= hit_p1_q;
        p2_q  <= hit_p2_q;
        tie_q <= !empty_q && !hit_p1_q && !hit_p2_q;
      end
    end
  end

  assign done        = done_q;
  assign p1_four_row = p1_q;
  assign p2_four_row = p2_q;
  assign tie_game    = tie_q;

endmodule

// File: tb/tb_c4_win_scanner.sv
// Directed bench for c4_win_scanner with a one-cycle-latency RAM model
// and a result scoreboard filled when each scan is started.
module tb_c4_win_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] read_pos;
  logic [1:0] read_data;
  logic       busy, done;
  logic       p1_four_row, p2_four_row, tie_game;

  c4_win_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .read_pos    (read_pos),
    .read_data   (read_data),
    .busy        (busy),
    .done        (done),
    .p1_four_row (p1_four_row),
    .p2_four_row (p2_four_row),
    .tie_game    (tie_game)
  );

  always #5 clk = ~clk;

  logic [1:0] ram [42];

  always @(posedge clk)
    read_data <= (read_pos < 6'd42) ? ram[read_pos] : 2'b00;

  typedef struct packed {
    logic p1;
    logic p2;
    logic tie;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [1:0] v);
    for (int i = 0; i < 42; i++) ram[i] = v;
  endtask

  task automatic tie_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        ram[r*7+c] = ((((c >> 1) & 1) ^ (r & 1)) != 0) ? 2'b10 : 2'b01;
  endtask

  task automatic run_scan(input string tag, input res_t exp, input bit poke);
    int   lat;
    int   nbusy;
    res_t got;
    lat   = 0;
    nbusy = 0;
    sb.push_back(exp);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) nbusy++;
      if (i == 5) check({tag, "_rdpos"}, 8'(read_pos), 8'd4);
      if (poke && i == 10) start = 1'b1;
      if (poke && i == 11) start = 1'b0;
      if (done && lat == 0) begin
        lat = i;
        check({tag, "_sb"}, 8'(sb.size() > 0), 8'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          check({tag, "_p1"},  8'(p1_four_row), 8'(got.p1));
          check({tag, "_p2"},  8'(p2_four_row), 8'(got.p2));
          check({tag, "_tie"}, 8'(tie_game),    8'(got.tie));
        end
        if (poke) start = 1'b1;
      end else if (lat != 0 && i == lat + 1) begin
        start = 1'b0;
        check({tag, "_idle"}, 8'({busy, done, read_pos}), 8'd0);
        break;
      end
    end
    start = 1'b0;
    check({tag, "_lat"},  8'(lat),   8'd87);
    check({tag, "_busy"}, 8'(nbusy), 8'd87);
  endtask

  initial begin
    int nd, nb;
    reset = 1'b0;
    start = 1'b0;
    fill(2'b00);
    repeat (3) @(negedge clk);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_pos",  8'(read_pos), 8'd0);
    check("rst_res",  8'({p1_four_row, p2_four_row, tie_game}), 8'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 8'(busy), 8'd0);

    run_scan("empty", '{p1: 0, p2: 0, tie: 0}, 1'b0);

    fill(2'b00);
    ram[3] = 2'b01; ram[4] = 2'b01; ram[5] = 2'b01; ram[6] = 2'b01;
    run_scan("hrow_edge", '{p1: 1, p2: 0, tie: 0}, 1'b1);

    fill(2'b00);
    ram[14] = 2'b10; ram[21] = 2'b10; ram[28] = 2'b10; ram[35] = 2'b10;
    run_scan("vert", '{p1: 0, p2: 1, tie: 0}, 1'b0);

    fill(2'b00);
    ram[0] = 2'b01; ram[8] = 2'b01; ram[16] = 2'b01; ram[24] = 2'b01;
    run_scan("diag_ur", '{p1: 1, p2: 0, tie: 0}, 1'b0);

    fill(2'b00);
    ram[5] = 2'b01; ram[6] = 2'b01; ram[7] = 2'b01; ram[8] = 2'b01;
    run_scan("wrap", '{p1: 0, p2: 0, tie: 0}, 1'b0);

    fill(2'b00);
    ram[3] = 2'b10; ram[9] = 2'b10; ram[15] = 2'b10; ram[21] = 2'b10;
    run_scan("diag_ul", '{p1: 0, p2: 1, tie: 0}, 1'b0);

    tie_board();
    run_scan("tie_full", '{p1: 0, p2: 0, tie: 1}, 1'b0);

    tie_board();
    ram[20] = 2'b00;
    run_scan("tie_hole", '{p1: 0, p2: 0, tie: 0}, 1'b0);

    tie_board();
    ram[41] = 2'b11;
    run_scan("tie_11", '{p1: 0, p2: 0, tie: 0}, 1'b0);

    fill(2'b11);
    run_scan("all_11", '{p1: 0, p2: 0, tie: 0}, 1'b0);

    fill(2'b00);
    ram[0]  = 2'b01; ram[1]  = 2'b01; ram[2]  = 2'b01; ram[3]  = 2'b01;
    ram[35] = 2'b10; ram[36] = 2'b10; ram[37] = 2'b10; ram[38] = 2'b10;
    run_scan("both", '{p1: 1, p2: 1, tie: 0}, 1'b0);

    // Abort a winning scan mid-flight; results from "both" must clear
    fill(2'b00);
    ram[3] = 2'b01; ram[4] = 2'b01; ram[5] = 2'b01; ram[6] = 2'b01;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy", 8'(busy), 8'd1);
    reset = 1'b0;
    #1;
    check("abort_ctl", 8'({busy, done}), 8'd0);
    check("abort_pos", 8'(read_pos), 8'd0);
    check("abort_res", 8'({p1_four_row, p2_four_row, tie_game}), 8'd0);
    @(negedge clk) reset = 1'b1;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    check("abort_nodone", 8'(nd), 8'd0);
    check("abort_nobusy", 8'(nb), 8'd0);

    fill(2'b00);
    ram[7] = 2'b10; ram[8] = 2'b10; ram[9] = 2'b10; ram[10] = 2'b10;
    run_scan("post_rst", '{p1: 0, p2: 1, tie: 0}, 1'b0);

    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
